// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches the decoded instruction, resolves the destination and masks $0 writes.
// Optional trace outputs (pcE, seqE) are built when ID_EX_TRACE_EN is defined.
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SEQ_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallE,
  input  logic              flushE,
  input  logic              validD,
  input  logic              regwriteD,
  input  logic              regdstD,
  input  logic              alusrcD,
  input  logic              branchD,
  input  logic              memwriteD,
  input  logic              memtoregD,
  input  logic              memenD,
  input  logic              jumpD,
  input  logic              pc8toregD,
  input  logic              writereg31D,
  input  logic              jumptoRsD,
  input  logic [7:0]        alucontrolD,
  input  logic [4:0]        rsD,
  input  logic [4:0]        rtD,
  input  logic [4:0]        rdD,
  input  logic [4:0]        saD,
  input  logic [DATA_W-1:0] srcaD,
  input  logic [DATA_W-1:0] srcbD,
  input  logic [DATA_W-1:0] signimmD,
  input  logic [DATA_W-1:0] pcplus8D,
  output logic              regwriteE,
  output logic              alusrcE,
  output logic              branchE,
  output logic              memwriteE,
  output logic              memtoregE,
  output logic              memenE,
  output logic              jumpE,
  output logic              pc8toregE,
  output logic              jumptoRsE,
  output logic [7:0]        alucontrolE,
  output logic [4:0]        rsE,
  output logic [4:0]        rtE,
  output logic [4:0]        rdE,
  output logic [4:0]        saE,
  output logic [DATA_W-1:0] srcaE,
  output logic [DATA_W-1:0] srcbE,
  output logic [DATA_W-1:0] signimmE,
  output logic [DATA_W-1:0] pcplus8E,
`ifdef ID_EX_TRACE_EN
  output logic [DATA_W-1:0] pcE,
  output logic [SEQ_W-1:0]  seqE,
`endif
  output logic [4:0]        writeregE,
  output logic              validE
);

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              alusrc;
    logic              branch;
    logic              memwrite;
    logic              memtoreg;
    logic              memen;
    logic              jump;
    logic              pc8toreg;
    logic              jumptors;
    logic [7:0]        alucontrol;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        sa;
    logic [4:0]        writereg;
    logic [DATA_W-1:0] srca;
    logic [DATA_W-1:0] srcb;
    logic [DATA_W-1:0] signimm;
    logic [DATA_W-1:0] pcplus8;
`ifdef ID_EX_TRACE_EN
    logic [DATA_W-1:0] pc;
    logic [SEQ_W-1:0]  seq;
`endif
  } ex_t;

  ex_t        ex_d;
  ex_t        ex_q;
  logic [4:0] dest;
  logic       dest_live;

`ifdef ID_EX_TRACE_EN
  logic [SEQ_W-1:0] seq_cnt;
`endif

  // A non-valid D slot yields the all-zero bubble, so only flush/reset need explicit clears below.
  always_comb begin
    ex_d      = '0;
    dest      = writereg31D ? 5'd31 : (regdstD ? rdD : rtD);
    dest_live = (dest != 5'd0);
    if (validD) begin
      ex_d.valid      = 1'b1;
      ex_d.regwrite   = regwriteD & dest_live;
      ex_d.alusrc     = alusrcD;
      ex_d.branch     = branchD;
      ex_d.memwrite   = memwriteD;
      ex_d.memtoreg   = memtoregD;
      ex_d.memen      = memenD;
      ex_d.jump       = jumpD;
      ex_d.pc8toreg   = pc8toregD & dest_live;
      ex_d.jumptors   = jumptoRsD;
      ex_d.alucontrol = alucontrolD;
      ex_d.rs         = rsD;
      ex_d.rt         = rtD;
      ex_d.rd         = rdD;
      ex_d.sa         = saD;
      ex_d.writereg   = dest;
      ex_d.srca       = srcaD;
      ex_d.srcb       = srcbD;
      ex_d.signimm    = signimmD;
      ex_d.pcplus8    = pcplus8D;
`ifdef ID_EX_TRACE_EN
      ex_d.pc         = pcplus8D - DATA_W'(8);
      ex_d.seq        = seq_cnt;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flushE) begin
      ex_q <= '0;
    end else if (!stallE) begin
      ex_q <= ex_d;
    end
  end

`ifdef ID_EX_TRACE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_cnt <= '0;
    end else if (!flushE && !stallE && validD) begin
      seq_cnt <= seq_cnt + SEQ_W'(1);
    end
  end

  assign pcE  = ex_q.pc;
  assign seqE = ex_q.seq;
`endif

  assign validE      = ex_q.valid;
  assign regwriteE   = ex_q.regwrite;
  assign alusrcE     = ex_q.alusrc;
  assign branchE     = ex_q.branch;
  assign memwriteE   = ex_q.memwrite;
  assign memtoregE   = ex_q.memtoreg;
  assign memenE      = ex_q.memen;
  assign jumpE       = ex_q.jump;
  assign pc8toregE   = ex_q.pc8toreg;
  assign jumptoRsE   = ex_q.jumptors;
  assign alucontrolE = ex_q.alucontrol;
  assign rsE         = ex_q.rs;
  assign rtE         = ex_q.rt;
  assign rdE         = ex_q.rd;
  assign saE         = ex_q.sa;
  assign writeregE   = ex_q.writereg;
  assign srcaE       = ex_q.srca;
  assign srcbE       = ex_q.srcb;
  assign signimmE    = ex_q.signimm;
  assign pcplus8E    = ex_q.pcplus8;

endmodule
